window3x3_builder: RTL and testbench

//  Builds the 3x3 neighbourhood of every pixel of a raster-scanned RGB444 frame.

---
 rtl/img_pkg.sv | 39 +++
 rtl/line_buffer.sv | 42 ++++
 rtl/window3x3_builder.sv | 217 +++++++++++++++++++++
 tb/tb_window3x3_builder.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/img_pkg.sv
// Shared definitions for the 3x3 window builder.
//   PIX_W           bits per RGB444 pixel {R,G,B}
//   R_W/G_W/B_W     colour field widths
//   SLOT_*          slot numbers inside the 9-slot window, SLOT_CENTRE is the MSB slot
//   WIN_W           width of one window
//   state_t         builder FSM states
//   slot_lsb()      lowest bit of a slot inside the window vector
package img_pkg;

    localparam int R_W   = 4;
    localparam int G_W   = 4;
    localparam int B_W   = 4;
    localparam int PIX_W = R_W + G_W + B_W;

    localparam int SLOT_CENTRE    = 8;
    localparam int SLOT_LEFT      = 7;
    localparam int SLOT_RIGHT     = 6;
    localparam int SLOT_UP        = 5;
    localparam int SLOT_DOWN      = 4;
    localparam int SLOT_UPLEFT    = 3;
    localparam int SLOT_UPRIGHT   = 2;
    localparam int SLOT_DOWNLEFT  = 1;
    localparam int SLOT_DOWNRIGHT = 0;

    localparam int WIN_W = 9 * PIX_W;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAD   = 3'd3,
        ST_FLUSH = 3'd4
    } state_t;

    function automatic int slot_lsb(input int slot);
        return slot * PIX_W;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// One-line delay RAM: every advance reads the word written DEPTH advances ago
// and overwrites it with din. The read is combinational from the current
// pointer, so dout is the "one line up" pixel for the column being accepted.
//   clk, reset  clock, asynchronous active-high reset (pointer only)
//   advance     perform one read/write and step the pointer
//   din         word to store
//   dout        word stored DEPTH advances earlier
module line_buffer #(
    parameter int DEPTH = 160,
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             advance,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    ptr;

    assign dout = mem[ptr];

    // Contents are don't-care after reset; only the pointer is cleared.
    always_ff @(posedge clk) begin
        if (advance) begin
            mem[ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (ptr == PTR_LAST) ? '0 : ptr + AW'(1);
        end
    end

endmodule

// File: rtl/window3x3_builder.sv
// Builds the 3x3 neighbourhood of every pixel of a raster-scanned RGB444 frame.
// Optional build macro: BORDER_ZERO_EN (out-of-frame neighbours read as zero
// instead of the replicated edge pixel; timing is identical).
//   clk, reset    clock, asynchronous active-high reset
//   frame_start   pulse one cycle before the first pixel; aborts a frame in progress
//   pix_in        raster-order pixel, accepted when pix_valid && in_ready
//   pix_valid     pix_in valid
//   in_ready      registered, high only in FILL and RUN
//   window_out    9 slots, MSB first: centre,left,right,up,down,upleft,upright,downleft,downright
//   window_valid  one-cycle strobe per window, no backpressure
//   center_x/y    coordinates of the window centre
//   frame_done    strobe together with the window for (W-1,H-1)
//   dbg_state     current FSM state
// Handshake: a pixel moves only on a cycle with pix_valid && in_ready; when
// in_ready is low the source must hold pix_in/pix_valid unchanged. A beat that
// coincides with frame_start is discarded because the frame restarts.
module window3x3_builder
    import img_pkg::*;
#(
    parameter int IMG_WIDTH  = 160,
    parameter int IMG_HEIGHT = 120
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_start,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             pix_valid,
    output logic             in_ready,
    output logic [WIN_W-1:0] window_out,
    output logic             window_valid,
    output logic [7:0]       center_x,
    output logic [7:0]       center_y,
    output logic             frame_done,
    output state_t           dbg_state
);

`ifdef BORDER_ZERO_EN
    localparam bit ZERO_PAD = 1'b1;
`else
    localparam bit ZERO_PAD = 1'b0;
`endif

    // Column counter also runs to IMG_WIDTH during FLUSH; row counter reaches
    // IMG_HEIGHT in FLUSH so that centre row is always row - 1.
    localparam int CW = $clog2(IMG_WIDTH + 1);
    localparam int RW = $clog2(IMG_HEIGHT + 1);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0] COL_END  = CW'(IMG_WIDTH);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    state_t           state;
    logic [CW-1:0]    col;
    logic [RW-1:0]    row;

    // Two previous columns of the three rows: u = y-1 (up), m = y (centre), d = y+1 (down).
    logic [PIX_W-1:0] u1, u2, m1, m2, d1, d2;
    logic [PIX_W-1:0] lb1_q, lb2_q;

    logic             accept, advance, emit;
    logic [CW-1:0]    emit_x;
    logic [RW-1:0]    emit_y;
    logic             left_edge, right_edge, top_edge, bot_edge;
    logic [PIX_W-1:0] px [3][3];
    logic [1:0]       r_up, r_dn, c_l, c_r;
    logic [WIN_W-1:0] win_next;

    assign dbg_state = state;

    // The newest column arriving this beat is {lb2_q, lb1_q, pix_in}.
    line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W)) u_lb_row1 (
        .clk     (clk),
        .reset   (reset),
        .advance (advance),
        .din     (pix_in),
        .dout    (lb1_q)
    );

    line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W)) u_lb_row2 (
        .clk     (clk),
        .reset   (reset),
        .advance (advance),
        .din     (lb1_q),
        .dout    (lb2_q)
    );

    assign accept  = pix_valid && in_ready && !frame_start;
    // FLUSH keeps clocking the line buffers to drain the last line; its final
    // cycle (col == COL_END) only emits the right-edge window.
    assign advance = accept || (state == ST_FLUSH && col != COL_END && !frame_start);
    assign emit    = !frame_start &&
                     ((accept && state == ST_RUN && col != '0) ||
                      state == ST_PAD ||
                      (state == ST_FLUSH && col != '0));

    assign emit_x = (state == ST_PAD) ? COL_LAST : col - CW'(1);
    assign emit_y = row - RW'(1);

    assign left_edge  = (emit_x == '0);
    assign right_edge = (emit_x == COL_LAST);
    assign top_edge   = (emit_y == '0);
    assign bot_edge   = (emit_y == ROW_LAST);

    function automatic logic [PIX_W-1:0] fill(input logic oob, input logic [PIX_W-1:0] v);
        return (ZERO_PAD && oob) ? '0 : v;
    endfunction

    // Clamping is done by redirecting the row/column index to the centre;
    // the zero build uses the same indices and then blanks out-of-frame slots.
    always_comb begin
        px[0][0] = u2;  px[0][1] = u1;  px[0][2] = lb2_q;
        px[1][0] = m2;  px[1][1] = m1;  px[1][2] = lb1_q;
        px[2][0] = d2;  px[2][1] = d1;  px[2][2] = pix_in;

        r_up = top_edge   ? 2'd1 : 2'd0;
        r_dn = bot_edge   ? 2'd1 : 2'd2;
        c_l  = left_edge  ? 2'd1 : 2'd0;
        c_r  = right_edge ? 2'd1 : 2'd2;

        win_next = '0;
        win_next[slot_lsb(SLOT_CENTRE)    +: PIX_W] = px[1][1];
        win_next[slot_lsb(SLOT_LEFT)      +: PIX_W] = fill(left_edge, px[1][c_l]);
        win_next[slot_lsb(SLOT_RIGHT)     +: PIX_W] = fill(right_edge, px[1][c_r]);
        win_next[slot_lsb(SLOT_UP)        +: PIX_W] = fill(top_edge, px[r_up][1]);
        win_next[slot_lsb(SLOT_DOWN)      +: PIX_W] = fill(bot_edge, px[r_dn][1]);
        win_next[slot_lsb(SLOT_UPLEFT)    +: PIX_W] = fill(top_edge | left_edge, px[r_up][c_l]);
        win_next[slot_lsb(SLOT_UPRIGHT)   +: PIX_W] = fill(top_edge | right_edge, px[r_up][c_r]);
        win_next[slot_lsb(SLOT_DOWNLEFT)  +: PIX_W] = fill(bot_edge | left_edge, px[r_dn][c_l]);
        win_next[slot_lsb(SLOT_DOWNRIGHT) +: PIX_W] = fill(bot_edge | right_edge, px[r_dn][c_r]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            in_ready     <= 1'b0;
            col          <= '0;
            row          <= '0;
            u1 <= '0; u2 <= '0; m1 <= '0; m2 <= '0; d1 <= '0; d2 <= '0;
            window_out   <= '0;
            window_valid <= 1'b0;
            center_x     <= '0;
            center_y     <= '0;
            frame_done   <= 1'b0;
        end else begin
            window_valid <= emit;
            frame_done   <= emit && state == ST_FLUSH && col == COL_END;
            if (emit) begin
                window_out <= win_next;
                center_x   <= 8'(emit_x);
                center_y   <= 8'(emit_y);
            end

            if (advance) begin
                u2 <= u1;  u1 <= lb2_q;
                m2 <= m1;  m1 <= lb1_q;
                d2 <= d1;  d1 <= pix_in;
            end

            if (frame_start) begin
                state    <= ST_FILL;
                in_ready <= 1'b1;
                col      <= '0;
                row      <= '0;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        in_ready <= 1'b0;
                    end
                    ST_FILL: begin
                        if (accept) begin
                            if (col == COL_LAST) begin
                                col   <= '0;
                                row   <= RW'(1);
                                state <= ST_RUN;
                            end else begin
                                col <= col + CW'(1);
                            end
                        end
                    end
                    ST_RUN: begin
                        if (accept) begin
                            if (col == COL_LAST) begin
                                col      <= '0;
                                state    <= ST_PAD;
                                in_ready <= 1'b0;
                            end else begin
                                col <= col + CW'(1);
                            end
                        end
                    end
                    ST_PAD: begin
                        row <= row + RW'(1);
                        if (row == ROW_LAST) begin
                            state <= ST_FLUSH;
                        end else begin
                            state    <= ST_RUN;
                            in_ready <= 1'b1;
                        end
                    end
                    ST_FLUSH: begin
                        if (col == COL_END) begin
                            col   <= '0;
                            row   <= '0;
                            state <= ST_IDLE;
                        end else begin
                            col <= col + CW'(1);
                        end
                    end
                    default: begin
                        state    <= ST_IDLE;
                        in_ready <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_window3x3_builder.sv
// Directed bench for window3x3_builder on a 4x3 frame with pixel = {0,y,x}.
module tb_window3x3_builder;
    import img_pkg::*;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int EW = 1 + 8 + 8 + 108;

`ifdef BORDER_ZERO_EN
    localparam bit ZERO_BENCH = 1'b1;
`else
    localparam bit ZERO_BENCH = 1'b0;
`endif

    // clock / reset
    logic          clk = 1'b0;
    logic          reset;
    logic          frame_start;
    logic [11:0]   pix_in;
    logic          pix_valid;
    logic          in_ready;
    logic [107:0]  window_out;
    logic          window_valid;
    logic [7:0]    center_x, center_y;
    logic          frame_done;
    state_t        dbg_state;

    always #5 clk = ~clk;

    window3x3_builder #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk          (clk),
        .reset        (reset),
        .frame_start  (frame_start),
        .pix_in       (pix_in),
        .pix_valid    (pix_valid),
        .in_ready     (in_ready),
        .window_out   (window_out),
        .window_valid (window_valid),
        .center_x     (center_x),
        .center_y     (center_y),
        .frame_done   (frame_done),
        .dbg_state    (dbg_state)
    );

    // scoreboard state
    int            checks = 0;
    int            errors = 0;
    logic [EW-1:0] exp_q[$];
    logic [107:0]  got_win [W*H];
    int            windows_seen = 0;
    int            stall_hits = 0;
    logic          prev_src = 1'b0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] pix_of(input int x, input int y);
        return {4'h0, y[3:0], x[3:0]};
    endfunction

    // Reference window by neighbour coordinates, slot order centre..downright.
    function automatic logic [107:0] model_win(input int x, input int y);
        logic [107:0] w;
        logic [11:0]  p;
        int           dx, dy, nx, ny;
        bit           oob;
        w = '0;
        for (int s = 0; s < 9; s++) begin
            case (s)
                0: begin dx =  0; dy =  0; end
                1: begin dx = -1; dy =  0; end
                2: begin dx =  1; dy =  0; end
                3: begin dx =  0; dy = -1; end
                4: begin dx =  0; dy =  1; end
                5: begin dx = -1; dy = -1; end
                6: begin dx =  1; dy = -1; end
                7: begin dx = -1; dy =  1; end
                default: begin dx = 1; dy = 1; end
            endcase
            nx  = x + dx;
            ny  = y + dy;
            oob = (nx < 0) || (nx >= W) || (ny < 0) || (ny >= H);
            if (nx < 0)  nx = 0;
            if (nx >= W) nx = W - 1;
            if (ny < 0)  ny = 0;
            if (ny >= H) ny = H - 1;
            p = (ZERO_BENCH && oob) ? 12'h000 : pix_of(nx, ny);
            w = {w[95:0], p};
        end
        return w;
    endfunction

    // monitor
    always @(posedge clk) begin
        prev_src = (pix_valid && in_ready) || dbg_state == ST_PAD || dbg_state == ST_FLUSH;
    end

    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (!reset) begin
            if (!window_valid) begin
                check("frame_done_idle", frame_done, 1'b0);
            end else begin
                windows_seen++;
                if (!prev_src) stall_hits++;
                if (exp_q.size() == 0) begin
                    check("unexpected_window", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("window", {frame_done, center_x, center_y, window_out}, e);
                    if (center_x < W && center_y < H)
                        got_win[int'(center_y) * W + int'(center_x)] = window_out;
                end
            end
        end
    end

    // driver tasks (called at a falling edge)
    task automatic start_frame();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic push_expected(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            exp_q.push_back({(i == W*H - 1), 8'(i % W), 8'(i / W), model_win(i % W, i / W)});
        end
    endtask

    task automatic send_pixels(input int first, input int last, input bit toggle);
        for (int i = first; i <= last; i++) begin
            int guard;
            guard     = 0;
            pix_in    = pix_of(i % W, i / W);
            pix_valid = 1'b1;
            while (!in_ready && guard < 40) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 40) check("ready_timeout", in_ready, 1'b1);
            @(negedge clk);
            if (toggle) begin
                pix_valid = 1'b0;
                @(negedge clk);
            end
        end
        pix_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_drain"}, exp_q.size(), 0);
        repeat (W + 4) @(negedge clk);
        check({tag, "_idle"}, dbg_state, ST_IDLE);
    endtask

    task automatic clear_got();
        for (int i = 0; i < W*H; i++) got_win[i] = '1;
    endtask

    localparam logic [107:0] W11 = 108'h011_010_012_001_021_000_002_020_022;
`ifdef BORDER_ZERO_EN
    localparam logic [107:0] W00 = 108'h000_000_001_000_010_000_000_000_011;
    localparam logic [107:0] W30 = 108'h003_002_000_000_013_000_000_012_000;
    localparam logic [11:0]  EDGE32 = 12'h000;
`else
    localparam logic [107:0] W00 = 108'h000_000_001_000_010_000_001_010_011;
    localparam logic [107:0] W30 = 108'h003_002_003_003_013_002_003_012_013;
    localparam logic [11:0]  EDGE32 = 12'h023;
`endif

    initial begin
        reset = 1'b1; frame_start = 1'b0; pix_valid = 1'b0; pix_in = '0;
        clear_got();
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_window_valid", window_valid, 1'b0);
        check("rst_window_out", window_out, '0);
        check("rst_center_x", center_x, 8'd0);
        check("rst_center_y", center_y, 8'd0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_state", dbg_state, ST_IDLE);
        reset = 1'b0;
        @(negedge clk);

        // reset in the middle of RUN
        start_frame();
        send_pixels(0, 4, 1'b0);
        check("run_before_reset", dbg_state, ST_RUN);
        check("ready_before_reset", in_ready, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_window_valid", window_valid, 1'b0);
        check("midrst_in_ready", in_ready, 1'b0);
        check("midrst_window_out", window_out, '0);
        check("midrst_state", dbg_state, ST_IDLE);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // contiguous frame
        clear_got();
        start_frame();
        push_expected(0, W*H - 1);
        send_pixels(0, W*H - 1, 1'b0);
        drain("full");
        check("hand_win_1_1", got_win[1*W + 1], W11);
        check("hand_win_0_0", got_win[0], W00);
        check("hand_win_3_0", got_win[3], W30);
        check("hand_3_2_down", got_win[2*W + 3][59:48], EDGE32);
        check("hand_3_2_right", got_win[2*W + 3][83:72], EDGE32);
        check("hand_3_2_downright", got_win[2*W + 3][11:0], EDGE32);

        // pix_valid toggling
        clear_got();
        start_frame();
        push_expected(0, W*H - 1);
        send_pixels(0, W*H - 1, 1'b1);
        drain("toggle");
        check("toggle_win_1_1", got_win[1*W + 1], W11);
        check("toggle_win_0_0", got_win[0], W00);

        // abort after 5 pixels, then a full frame
        start_frame();
        send_pixels(0, 4, 1'b0);
        start_frame();
        push_expected(0, W*H - 1);
        send_pixels(0, W*H - 1, 1'b0);
        drain("abort_run");

        // abort at the start of FLUSH: last row windows must never appear
        start_frame();
        push_expected(0, 2*W - 1);
        send_pixels(0, W*H - 1, 1'b0);
        begin
            int guard;
            guard = 0;
            while (dbg_state != ST_FLUSH && guard < 20) begin
                @(negedge clk);
                guard++;
            end
        end
        check("flush_reached", dbg_state, ST_FLUSH);
        start_frame();
        check("abort_flush_fill", dbg_state, ST_FILL);
        push_expected(0, W*H - 1);
        send_pixels(0, W*H - 1, 1'b0);
        drain("abort_flush");

        check("stall_windows", stall_hits, 0);
        check("windows_total", windows_seen, 4*W*H + 2*W);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
